awb_gain: RTL and testbench
===========================

// Module: awb_gain
// PURPOSE
//  Gray-world auto white balance; sits directly downstream of the CFA demosaic stage.
//  Accumulates R/G/B sums over each frame's valid pixels (in_den=1).
//  At end of frame, a sequential divider computes R and B gains that normalise them to G.
//  Applies the gains to the next frame's RGB stream; G passes through delay-matched with gain 1.0.
// PARAMETERS
//  SUM_W      28   width of per-channel frame accumulators (512x512x255 < 2^28)
//  GAIN_W     12   gain width, unsigned fixed point Q4.8
//  GAIN_FRAC  8    fractional gain bits; 1.0 = 12'h100
// PORTS
//  clk        in   1      pixel clock
//  reset_n    in   1      reset, asynchronous, active-low
//  in_vsync   in   1      high during active frame
//  in_hsync   in   1      high during active line
//  in_den     in   1      pixel valid
//  in_R/G/B   in   8 ea   demosaiced pixel
//  out_vsync  out  1      in_vsync delayed 2 clk
//  out_hsync  out  1      in_hsync delayed 2 clk
//  out_den    out  1      in_den delayed 2 clk
//  out_R/G/B  out  8 ea   balanced pixel
//  gain_r     out  12     active R gain (Q4.8)
//  gain_b     out  12     active B gain (Q4.8)
//  busy       out  1      divider FSM not IDLE
// BEHAVIOUR
//  Reset: all outputs 0 except gain_r = gain_b = 12'h100; accumulators 0; pending gains 12'h100; FSM IDLE.
//  Datapath, latency 2 clk, fixed:
//   - S1: products p = in_X * gain_X (20 b).
//   - S2: out_X = |p[19:16] ? 8'hFF : p[15:8] (truncate, saturate at 255).
//   - out_G = in_G delayed 2 clk. Sync/den delayed identically; pixels are processed regardless of den.
//  Statistics: when in_vsync=1 and in_den=1, sumR/G/B += in_R/G/B (saturate at all-ones).
//  Vsync falling edge (registered compare):
//   - latch sums into divider operands, clear accumulators, FSM IDLE -> DIV_R.
//  Divider: restoring, 1 quotient bit/clk, Q = (sumG<<8)/sumX, 12 bits.
//   - DIV_R: 1 clk setup + 12 iterations -> pend_r.
//   - DIV_B: same for B -> pend_b.
//   - DONE: 1 clk, sets pend_valid, then IDLE. Total 28 clk from vsync fall to pend_valid.
//   - sumX==0: result 12'h100.
//   - (sumG<<8) >= (sumX<<12), overflow: result 12'hFFF.
//  Gain update: on vsync rising edge, if pend_valid, gain_r/gain_b <= pend_r/pend_b and pend_valid clears.
//   Gains never change mid-frame.
//  Vsync rising while busy: old gains kept; results apply at the following frame start.
//  Vsync falling while busy (blanking+frame < 28 clk): ignored, sums still cleared, FSM completes current job.
//  reset_n asserted mid-division: aborts; FSM IDLE; no gain update.
// CONFIGURATION
//  AWB_MANUAL_EN defined: adds ports
//   - man_en  in  1
//   - man_gain_r in 12, man_gain_b in 12
//   When man_en=1 at vsync rise, active gains load from man_gain_r/b instead of pend; statistics and divider still run.
//  AWB_MANUAL_EN undefined: ports absent; gains come only from the divider.
// TESTING
//  T1 reset, no frame, in R/G/B=10/20/30 -> out 10/20/30 two clk later; gain_r=gain_b=12'h100.
//  T2 16x16 frame R=64,G=128,B=32 -> 28 clk after vsync fall pend_r=12'h200, pend_b=12'h400; next frame 64/128/32 -> out 128/128/128.
//  T3 gain_r=12'h200, in_R=200 -> out_R=255 (saturate).
//  T4 frame R=0 G=100 B=100 -> gain_r=12'h100, gain_b=12'h100. Frame G=255 R=1 -> gain_r=12'hFFF.
//  T5 next vsync rise at 10 clk after fall -> gains unchanged for that frame, updated at following rise; reset_n pulse mid-DIV_B -> gains 12'h100, busy=0.
//  T6 AWB_MANUAL_EN, man_en=1, man_gain_r=12'h180 -> gain_r=12'h180 at next vsync rise; in_R=100 -> out_R=150.

Source files
------------

// File: rtl/awb_gain.sv
// awb_gain: gray-world auto white balance with per-frame R/B gain computed by a restoring divider.
// Optional manual gain override is compiled in with AWB_MANUAL_EN.
module awb_gain #(
    parameter int SUM_W     = 28,
    parameter int GAIN_W    = 12,
    parameter int GAIN_FRAC = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_vsync,
    input  logic              in_hsync,
    input  logic              in_den,
    input  logic [7:0]        in_R,
    input  logic [7:0]        in_G,
    input  logic [7:0]        in_B,
`ifdef AWB_MANUAL_EN
    input  logic              man_en,
    input  logic [GAIN_W-1:0] man_gain_r,
    input  logic [GAIN_W-1:0] man_gain_b,
`endif
    output logic              out_vsync,
    output logic              out_hsync,
    output logic              out_den,
    output logic [7:0]        out_R,
    output logic [7:0]        out_G,
    output logic [7:0]        out_B,
    output logic [GAIN_W-1:0] gain_r,
    output logic [GAIN_W-1:0] gain_b,
    output logic              busy
);
    localparam logic [1:0] IDLE = 2'd0, DIV_R = 2'd1, DIV_B = 2'd2, DONE = 2'd3;
    localparam int PW = 8 + GAIN_W;
    localparam int IB = GAIN_W - GAIN_FRAC;
    localparam int CW = $clog2(GAIN_W + 1);
    localparam logic [GAIN_W-1:0] ONE = GAIN_W'(1 << GAIN_FRAC);

    function automatic logic [7:0] sat(input logic [PW-1:0] p);
        return |p[PW-1:GAIN_FRAC+8] ? 8'hFF : p[GAIN_FRAC+7:GAIN_FRAC];
    endfunction

    function automatic logic [SUM_W-1:0] acc(input logic [SUM_W-1:0] s, input logic [7:0] x);
        logic [SUM_W:0] t;
        t = {1'b0, s} + (SUM_W+1)'(x);
        return t[SUM_W] ? '1 : t[SUM_W-1:0];
    endfunction

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic              vs_d, rise, fall;
    logic [PW-1:0]     p_r, p_b;
    logic [7:0]        g_d;
    logic [2:0]        sync_d;
    logic [SUM_W-1:0]  sum_r, sum_g, sum_b, op_r, op_g, op_b, dv, rem, dsel, rem_nx;
    logic [SUM_W:0]    rem_sh, diff;
    logic [GAIN_W-1:0] n_lo, q, q_nx, res, spec_val, pend_r, pend_b, man_r, man_b;
    logic              spec, ge, pend_valid, man_sel;

`ifdef AWB_MANUAL_EN
    assign man_sel = man_en;
    assign man_r   = man_gain_r;
    assign man_b   = man_gain_b;
`else
    assign man_sel = 1'b0;
    assign man_r   = ONE;
    assign man_b   = ONE;
`endif

    assign rise = in_vsync & ~vs_d;
    assign fall = ~in_vsync & vs_d;
    assign busy = state != IDLE;

    always_comb begin
        dsel   = state == DIV_R ? op_r : op_b;
        rem_sh = {rem, n_lo[GAIN_W-1]};
        diff   = rem_sh - {1'b0, dv};
        ge     = rem_sh >= {1'b0, dv};
        rem_nx = ge ? diff[SUM_W-1:0] : rem_sh[SUM_W-1:0];
        q_nx   = {q[GAIN_W-2:0], ge};
        res    = spec ? spec_val : q_nx;
    end

    // two-stage pixel pipeline; G only needs delay matching
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_r <= '0;
            p_b <= '0;
            g_d <= '0;
            sync_d <= '0;
            {out_vsync, out_hsync, out_den} <= '0;
            out_R <= '0;
            out_G <= '0;
            out_B <= '0;
        end else begin
            p_r <= in_R * gain_r;
            p_b <= in_B * gain_b;
            g_d <= in_G;
            sync_d <= {in_vsync, in_hsync, in_den};
            {out_vsync, out_hsync, out_den} <= sync_d;
            out_R <= sat(p_r);
            out_G <= g_d;
            out_B <= sat(p_b);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt <= '0;
            vs_d <= 1'b0;
            {sum_r, sum_g, sum_b, op_r, op_g, op_b, dv, rem} <= '0;
            n_lo <= '0;
            q <= '0;
            spec <= 1'b0;
            spec_val <= '0;
            pend_r <= ONE;
            pend_b <= ONE;
            pend_valid <= 1'b0;
            gain_r <= ONE;
            gain_b <= ONE;
        end else begin
            vs_d <= in_vsync;
            if (fall) begin
                sum_r <= '0;
                sum_g <= '0;
                sum_b <= '0;
            end else if (in_vsync && in_den) begin
                sum_r <= acc(sum_r, in_R);
                sum_g <= acc(sum_g, in_G);
                sum_b <= acc(sum_b, in_B);
            end
            if (fall && state == IDLE) begin
                op_r <= sum_r;
                op_g <= sum_g;
                op_b <= sum_b;
                cnt <= '0;
                state <= DIV_R;
            end else if ((state == DIV_R || state == DIV_B) && cnt == '0) begin
                // numerator is sumG << GAIN_FRAC; top bits seed the remainder
                rem <= op_g >> IB;
                n_lo <= {op_g[IB-1:0], {GAIN_FRAC{1'b0}}};
                dv <= dsel;
                q <= '0;
                spec <= (dsel == '0) || ((op_g >> IB) >= dsel);
                spec_val <= (dsel == '0) ? ONE : '1;
                cnt <= 1'b1;
            end else if (state == DIV_R || state == DIV_B) begin
                rem <= rem_nx;
                n_lo <= n_lo << 1;
                q <= q_nx;
                cnt <= cnt + 1'b1;
                if (cnt == CW'(GAIN_W)) begin
                    cnt <= '0;
                    if (state == DIV_R) pend_r <= res;
                    else pend_b <= res;
                    state <= state == DIV_R ? DIV_B : DONE;
                end
            end else if (state == DONE) begin
                pend_valid <= 1'b1;
                state <= IDLE;
            end
            // gains only move at frame start, and never while a result is half-written
            if (rise && man_sel) begin
                gain_r <= man_r;
                gain_b <= man_b;
            end else if (rise && pend_valid && state == IDLE) begin
                gain_r <= pend_r;
                gain_b <= pend_b;
                pend_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_awb_gain.sv
// tb_awb_gain: directed self-checking bench for awb_gain.
// Define AWB_MANUAL_EN to also exercise the manual gain override.
module tb_awb_gain;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_vsync = 1'b0, in_hsync = 1'b0, in_den = 1'b0;
    logic [7:0]  in_R = '0, in_G = '0, in_B = '0;
    logic        out_vsync, out_hsync, out_den;
    logic [7:0]  out_R, out_G, out_B;
    logic [11:0] gain_r, gain_b;
    logic        busy;
`ifdef AWB_MANUAL_EN
    logic        man_en = 1'b0;
    logic [11:0] man_gain_r = '0, man_gain_b = '0;
`endif
    int tests = 0, fails = 0;

    awb_gain dut (
        .clk(clk), .reset_n(reset_n),
        .in_vsync(in_vsync), .in_hsync(in_hsync), .in_den(in_den),
        .in_R(in_R), .in_G(in_G), .in_B(in_B),
`ifdef AWB_MANUAL_EN
        .man_en(man_en), .man_gain_r(man_gain_r), .man_gain_b(man_gain_b),
`endif
        .out_vsync(out_vsync), .out_hsync(out_hsync), .out_den(out_den),
        .out_R(out_R), .out_G(out_G), .out_B(out_B),
        .gain_r(gain_r), .gain_b(gain_b), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        in_R = r;
        in_G = g;
        in_B = b;
    endtask

    task automatic start();
        in_vsync = 1'b1;
        in_hsync = 1'b1;
        tick(1);
    endtask

    task automatic stop();
        in_vsync = 1'b0;
        in_hsync = 1'b0;
        in_den = 1'b0;
        tick(1);
    endtask

    task automatic pixels(input int n, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        pix(r, g, b);
        in_den = 1'b1;
        tick(n);
        in_den = 1'b0;
    endtask

    initial begin
        tick(2);
        chk("rst_gain_r", gain_r, 12'h100);
        chk("rst_gain_b", gain_b, 12'h100);
        chk("rst_out_R", out_R, 0);
        chk("rst_busy", busy, 0);
        reset_n = 1'b1;
        // T1: unity gain passthrough with 2-clk latency
        pix(10, 20, 30);
        tick(1);
        chk("t1_lat1_R", out_R, 0);
        tick(1);
        chk("t1_R", out_R, 10);
        chk("t1_G", out_G, 20);
        chk("t1_B", out_B, 30);
        // T2: 16x16 frame, divider timing and gain application
        start();
        chk("t2_first_rise_r", gain_r, 12'h100);
        pixels(256, 64, 128, 32);
        stop();
        chk("t2_busy_e0", busy, 1);
        tick(26);
        chk("t2_busy_e26", busy, 1);
        tick(1);
        chk("t2_idle_e27", busy, 0);
        start();
        chk("t2_gain_r", gain_r, 12'h200);
        chk("t2_gain_b", gain_b, 12'h400);
        pix(64, 128, 32);
        in_den = 1'b1;
        tick(2);
        chk("t2_out_R", out_R, 128);
        chk("t2_out_G", out_G, 128);
        chk("t2_out_B", out_B, 128);
        chk("t2_out_den", out_den, 1);
        // T3: saturation
        pix(200, 128, 32);
        tick(2);
        chk("t3_sat_R", out_R, 255);
        chk("t3_out_B", out_B, 128);
        stop();
        tick(30);
        // T4: sums R=528 G=512 B=128 from the previous frame
        start();
        chk("t4_prev_gain_r", gain_r, 12'h0F8);
        chk("t4_prev_gain_b", gain_b, 12'h400);
        pixels(4, 0, 100, 100);
        stop();
        tick(30);
        start();
        chk("t4_zero_r", gain_r, 12'h100);
        chk("t4_unity_b", gain_b, 12'h100);
        pixels(4, 1, 255, 255);
        stop();
        tick(30);
        // T5: overflow result, then a frame start during the divide
        start();
        chk("t4_ovf_r", gain_r, 12'hFFF);
        chk("t4_ovf_b", gain_b, 12'h100);
        pixels(4, 50, 100, 25);
        stop();
        tick(9);
        start();
        chk("t5_busy_rise_r", gain_r, 12'hFFF);
        chk("t5_busy_rise_b", gain_b, 12'h100);
        chk("t5_busy_rise_busy", busy, 1);
        tick(4);
        stop();
        tick(25);
        chk("t5_idle", busy, 0);
        start();
        chk("t5_late_r", gain_r, 12'h200);
        chk("t5_late_b", gain_b, 12'h400);
        pixels(4, 100, 200, 50);
        stop();
        tick(19);
        chk("t5_busy_divb", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("t5_abort_r", gain_r, 12'h100);
        chk("t5_abort_b", gain_b, 12'h100);
        chk("t5_abort_busy", busy, 0);
        tick(1);
        reset_n = 1'b1;
        tick(40);
        start();
        chk("t5_no_update_r", gain_r, 12'h100);
        chk("t5_no_update_b", gain_b, 12'h100);
        stop();
        tick(2);
`ifdef AWB_MANUAL_EN
        // T6: manual override at frame start
        man_en = 1'b1;
        man_gain_r = 12'h180;
        man_gain_b = 12'h100;
        start();
        chk("t6_man_r", gain_r, 12'h180);
        pix(100, 0, 0);
        in_den = 1'b1;
        tick(2);
        chk("t6_out_R", out_R, 150);
        stop();
        man_en = 1'b0;
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
